metrics_counter_bank: RTL and testbench
=======================================

Name: metrics_counter_bank

Overview:
Multi-channel performance-metrics counter bank. It is the generalised successor of the single-channel enable/clear event counter.
- Counts NUM_CH independent event streams, each with a per-cycle increment amount.
- Counting is gated by a measurement-window state machine (manual start/stop or a fixed cycle window).
- Saturating or wrapping arithmetic with sticky overflow flags.
- Atomic snapshot into shadow registers, read out through an indexed port.
- Sits beside the matrix accelerator datapath; feeds the debug/CSR read path.

Parameters:
NUM_CH, 4, number of counter channels (>=1)
COUNTER_WIDTH, 32, width of each live and shadow counter
INC_WIDTH, 4, width of each per-channel increment amount
WIN_WIDTH, 32, width of window length and window cycle counter
SATURATE, 0, 1 = clamp at max value; 0 = wrap modulo 2^COUNTER_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse: clear all counters/flags, sample win_len, enter RUN
stop  in  1  pulse: end window (RUN only), snapshot, enter DONE
win_len  in  WIN_WIDTH  window length in cycles; 0 = unbounded; sampled on start
clear  in  1  zero all live counters and overflow flags; state unchanged
snap  in  1  copy post-update live counters and flags to shadow
inc_valid  in  NUM_CH  per-channel event strobe
inc_amt  in  NUM_CH*INC_WIDTH  per-channel increment amount, channel i at [i*INC_WIDTH +: INC_WIDTH]
rd_en  in  1  read request
rd_idx  in  max(1,$clog2(NUM_CH))  channel to read
rd_valid  out  1  read data valid, one cycle after rd_en
rd_data  out  COUNTER_WIDTH  shadow counter value
rd_ovf  out  1  shadow overflow flag
running  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Clock and reset are decided: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All live counters, shadow counters, overflow flags, window counter and latched win_len = 0.
  - rd_valid = 0, rd_data = 0, rd_ovf = 0, running = 0, done = 0.
- Reset mid-window aborts immediately; no snapshot is taken.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE --start--> RUN.
  - RUN --start--> RUN (restart).
  - RUN --stop--> DONE.
  - RUN --window end--> DONE.
  - stop outside RUN is ignored.
- Event priority per cycle: rst > start > clear > (stop | window end | snap) > increment.
- start cycle:
  - Live counters, flags and window counter go to 0.
  - win_len is latched.
  - That cycle's increments are discarded.
  - Shadow registers are not changed.
- Counting:
  - Only in cycles where state == RUN (registered state).
  - Channel i adds inc_amt[i] when inc_valid[i] = 1.
  - The result is visible on the next cycle.
  - inc_amt = 0 with valid is a no-op.
- Arithmetic:
  - Sum is computed at COUNTER_WIDTH+1 bits; carry-out = overflow.
  - SATURATE=1: result clamps to all-ones and the flag sets.
  - SATURATE=0: result wraps and the flag sets.
  - Flags are sticky until rst, start or clear.
- Window:
  - Window counter increments every RUN cycle.
  - If latched win_len != 0 and the window counter == win_len-1, this is the final counted cycle.
  - The final cycle's increments count; state -> DONE; snapshot is taken.
  - Exactly win_len cycles are counted.
- stop in RUN: the stop cycle's increments count; snapshot is taken; state -> DONE.
- Snapshot (snap, stop, window end):
  - Shadow gets the post-update value of every channel (this cycle's increment included) plus flags.
  - Atomic across all channels.
- clear in the same cycle as a snapshot: shadow captures 0 and flags 0.
- start and stop in the same cycle: start wins; no snapshot.
- Read:
  - rd_en in cycle N gives rd_valid = 1 in N+1.
  - rd_data/rd_ovf hold the shadow value as registered at the end of cycle N (pre-update shadow for that cycle).
  - rd_valid = 0 when rd_en = 0; rd_data holds its last value.
  - rd_idx >= NUM_CH: rd_valid = 1, rd_data = 0, rd_ovf = 0.
  - Back-to-back reads are supported every cycle.

Test Plan:
1. rst; start with win_len=10; ch0 valid every cycle, amt=1; ch1 amt=3 on alternate cycles -> done after 10 RUN cycles; read ch0=10, ch1=15, ovf=0.
2. win_len=0; start, 7 RUN cycles ch2 amt=2, then stop with ch2 amt=5 in the stop cycle -> shadow ch2=19; done=1; a further stop is ignored.
3. COUNTER_WIDTH=8, SATURATE=1: amt=15 for 20 cycles -> ch0=255, rd_ovf=1. Same with SATURATE=0 -> ch0=(300 mod 256)=44, rd_ovf=1.
4. Mid-RUN: snap and clear in the same cycle -> shadow=0. snap alone next cycle -> shadow = that cycle's increment only. start during RUN -> counters zeroed, state stays RUN.
5. Reads: rd_en on consecutive cycles, idx 0,1,NUM_CH -> rd_valid three cycles; third read returns data=0, ovf=0. rd_en in the same cycle as snap returns the old shadow.
6. rst asserted mid-window with counts of 40 -> next cycle all outputs 0, state IDLE, shadow 0, increments ignored until start.

Source files
------------

// File: rtl/metrics_counter_bank.sv
// metrics_counter_bank: a bank of per-channel event counters. A measurement
// window (manual start/stop, or a fixed number of cycles) gates counting.
// Each channel saturates or wraps and keeps a sticky overflow flag. All
// channels are copied at once into shadow registers, which are read back
// one channel at a time through an indexed port.
module metrics_counter_bank #(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int INC_WIDTH     = 4,
    parameter int WIN_WIDTH     = 32,
    parameter int SATURATE      = 0,
    localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [WIN_WIDTH-1:0]          win_len,
    input  logic                          clear,
    input  logic                          snap,
    input  logic [NUM_CH-1:0]             inc_valid,
    input  logic [NUM_CH*INC_WIDTH-1:0]   inc_amt,
    input  logic                          rd_en,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic                          rd_valid,
    output logic [COUNTER_WIDTH-1:0]      rd_data,
    output logic                          rd_ovf,
    output logic                          running,
    output logic                          done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

    state_t                              state_reg, state_next;
    logic [WIN_WIDTH-1:0]                win_cnt_reg;
    logic [WIN_WIDTH-1:0]                win_len_reg;
    logic                                win_end;
    logic                                counting;
    logic                                snap_take;
    logic [NUM_CH-1:0][COUNTER_WIDTH-1:0] sh_cnt_bus;
    logic [NUM_CH-1:0]                   sh_ovf_bus;
    logic                                rd_valid_reg;
    logic [COUNTER_WIDTH-1:0]            rd_data_reg;
    logic                                rd_ovf_reg;

    // This is the last counted cycle of a bounded window.
    assign win_end = (state_reg == ST_RUN) && (win_len_reg != '0) &&
                     (win_cnt_reg == win_len_reg - WIN_ONE);

    // start discards the increments of its own cycle.
    assign counting  = (state_reg == ST_RUN) && !start;

    // A snapshot is taken on an explicit snap, or when a window ends through
    // stop or timeout. start suppresses all of these.
    assign snap_take = !start &&
                       (snap || ((state_reg == ST_RUN) && (stop || win_end)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state. start has priority over everything else. stop is honoured in RUN only.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_RUN;
        end else if ((state_reg == ST_RUN) && (stop || win_end)) begin
            state_next = ST_DONE;
        end
    end

    // Window cycle counter, plus the window length latched when start is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_reg <= '0;
            win_len_reg <= '0;
        end else if (start) begin
            win_cnt_reg <= '0;
            win_len_reg <= win_len;
        end else if (state_reg == ST_RUN) begin
            win_cnt_reg <= win_cnt_reg + WIN_ONE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [COUNTER_WIDTH-1:0] cnt_reg;
            logic                     ovf_reg;
            logic [COUNTER_WIDTH-1:0] sh_cnt_reg;
            logic                     sh_ovf_reg;
            logic [COUNTER_WIDTH:0]   amt_ext;
            logic [COUNTER_WIDTH:0]   sum;
            logic [COUNTER_WIDTH-1:0] cnt_next;
            logic                     ovf_next;

            assign amt_ext = (COUNTER_WIDTH+1)'(inc_amt[gi*INC_WIDTH +: INC_WIDTH]);

            // Post-update live value. Its carry-out sets the sticky flag.
            always_comb begin
                sum      = {1'b0, cnt_reg} + amt_ext;
                cnt_next = cnt_reg;
                ovf_next = ovf_reg;
                if (counting && inc_valid[gi]) begin
                    if (sum[COUNTER_WIDTH]) begin
                        ovf_next = 1'b1;
                        cnt_next = (SATURATE != 0) ? {COUNTER_WIDTH{1'b1}}
                                                   : sum[COUNTER_WIDTH-1:0];
                    end else begin
                        cnt_next = sum[COUNTER_WIDTH-1:0];
                    end
                end
            end

            // Live counter, flag and shadow copy. clear zeroes what a snapshot would capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg    <= '0;
                    ovf_reg    <= 1'b0;
                    sh_cnt_reg <= '0;
                    sh_ovf_reg <= 1'b0;
                end else if (start) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else begin
                    if (clear) begin
                        cnt_reg <= '0;
                        ovf_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_next;
                        ovf_reg <= ovf_next;
                    end
                    if (snap_take) begin
                        sh_cnt_reg <= clear ? '0 : cnt_next;
                        sh_ovf_reg <= clear ? 1'b0 : ovf_next;
                    end
                end
            end

            assign sh_cnt_bus[gi] = sh_cnt_reg;
            assign sh_ovf_bus[gi] = sh_ovf_reg;
        end
    endgenerate

    // Registered read of the shadow bank. An out-of-range index returns zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_ovf_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                if (int'(rd_idx) < NUM_CH) begin
                    rd_data_reg <= sh_cnt_bus[rd_idx];
                    rd_ovf_reg  <= sh_ovf_bus[rd_idx];
                end else begin
                    rd_data_reg <= '0;
                    rd_ovf_reg  <= 1'b0;
                end
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign rd_ovf   = rd_ovf_reg;
    assign running  = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Directed testbench for metrics_counter_bank. Two instances share every
// input: one saturates and one wraps. Expected read results go into a
// scoreboard queue when a read is issued. They are taken back out and
// compared when the read data comes back.
module tb_metrics_counter_bank;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int IW  = 4;
    localparam int WW  = 16;

    logic              clk = 1'b0;
    logic              rst, start, stop, clear, snap, rd_en;
    logic [WW-1:0]     win_len;
    logic [NCH-1:0]    inc_valid;
    logic [NCH*IW-1:0] inc_amt;
    logic [1:0]        rd_idx;

    logic          rd_valid_s, rd_ovf_s, running_s, done_s;
    logic [CW-1:0] rd_data_s;
    logic          rd_valid_w, rd_ovf_w, running_w, done_w;
    logic [CW-1:0] rd_data_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    d_sat;
        int    o_sat;
        int    d_wrap;
        int    o_wrap;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    always #5 clk = ~clk;

    metrics_counter_bank #(
        .NUM_CH(NCH), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .WIN_WIDTH(WW), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len),
        .clear(clear), .snap(snap), .inc_valid(inc_valid), .inc_amt(inc_amt),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
        .rd_ovf(rd_ovf_s), .running(running_s), .done(done_s)
    );

    metrics_counter_bank #(
        .NUM_CH(NCH), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .WIN_WIDTH(WW), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len),
        .clear(clear), .snap(snap), .inc_valid(inc_valid), .inc_amt(inc_amt),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_w), .rd_data(rd_data_w),
        .rd_ovf(rd_ovf_w), .running(running_w), .done(done_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge. Then pop and compare any read issued in that cycle.
    task automatic tick();
        logic had_rd;
        rd_exp_t e;
        had_rd = rd_en;
        @(posedge clk);
        #1;
        if (had_rd) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                e = sb_q.pop_front();
                chk({e.tag, "_valid_sat"},  32'(rd_valid_s), 32'd1);
                chk({e.tag, "_data_sat"},   32'(rd_data_s),  e.d_sat);
                chk({e.tag, "_ovf_sat"},    32'(rd_ovf_s),   e.o_sat);
                chk({e.tag, "_valid_wrap"}, 32'(rd_valid_w), 32'd1);
                chk({e.tag, "_data_wrap"},  32'(rd_data_w),  e.d_wrap);
                chk({e.tag, "_ovf_wrap"},   32'(rd_ovf_w),   e.o_wrap);
                $display("read %s idx-result sat=%0d/%0d wrap=%0d/%0d", e.tag,
                         rd_data_s, rd_ovf_s, rd_data_w, rd_ovf_w);
            end
        end else begin
            chk("rd_valid_idle_sat",  32'(rd_valid_s), 32'd0);
            chk("rd_valid_idle_wrap", 32'(rd_valid_w), 32'd0);
        end
    endtask

    task automatic rd(input string tag, input int idx, input int ds, input int os,
                      input int dw, input int ow);
        rd_en  = 1'b1;
        rd_idx = idx[1:0];
        sb_q.push_back('{tag, ds, os, dw, ow});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic set_inc(input int ch, input logic v, input int amt);
        inc_valid[ch]        = v;
        inc_amt[ch*IW +: IW] = amt[IW-1:0];
    endtask

    task automatic chk_state(input string tag, input logic run_e, input logic done_e);
        chk({tag, "_running"}, 32'(running_s), 32'(run_e));
        chk({tag, "_done"},    32'(done_s),    32'(done_e));
        chk({tag, "_running_wrap"}, 32'(running_w), 32'(run_e));
    endtask

    task automatic do_start(input int wl);
        start   = 1'b1;
        win_len = wl[WW-1:0];
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; snap = 1'b0;
        rd_en = 1'b0; rd_idx = '0; win_len = '0; inc_valid = '0; inc_amt = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 1'b0, 1'b0);
        chk("reset_rd_data", 32'(rd_data_s), 32'd0);
        chk("reset_rd_ovf",  32'(rd_ovf_s),  32'd0);

        // 1: ten-cycle window
        do_start(10);
        chk_state("t1_start", 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            set_inc(0, 1'b1, 1);
            set_inc(1, (k % 2) == 0, 3);
            if (k == 9) chk_state("t1_before_end", 1'b1, 1'b0);
            tick();
        end
        inc_valid = '0;
        chk_state("t1_end", 1'b0, 1'b1);
        rd("t1_ch0", 0, 10, 0, 10, 0);
        rd("t1_ch1", 1, 15, 0, 15, 0);
        rd("t1_ch2", 2, 0, 0, 0, 0);

        // 2: unbounded window, stop counts its own cycle
        do_start(0);
        for (int k = 0; k < 7; k++) begin
            set_inc(2, 1'b1, 2);
            tick();
        end
        set_inc(2, 1'b1, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        inc_valid = '0;
        chk_state("t2_stop", 1'b0, 1'b1);
        stop = 1'b1; clear = 1'b1;
        tick();
        stop = 1'b0; clear = 1'b0;
        chk_state("t2_stop_ignored", 1'b0, 1'b1);
        rd("t2_ch2", 2, 19, 0, 19, 0);
        rd("t2_ch0", 0, 0, 0, 0, 0);

        // 3: overflow, saturating vs wrapping
        do_start(20);
        for (int k = 0; k < 20; k++) begin
            set_inc(0, 1'b1, 15);
            tick();
        end
        inc_valid = '0;
        chk_state("t3_end", 1'b0, 1'b1);
        rd("t3_ch0", 0, 255, 1, 44, 1);
        rd("t3_ch1", 1, 0, 0, 0, 0);

        // 4: snap+clear, snap alone, restart during RUN
        do_start(0);
        for (int k = 0; k < 3; k++) begin
            set_inc(0, 1'b1, 4);
            tick();
        end
        snap = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        set_inc(0, 1'b1, 7);
        set_inc(1, 1'b1, 0);
        rd("t4_rd_with_snap", 0, 0, 0, 0, 0);
        snap = 1'b0;
        inc_valid = '0;
        rd("t4_snap_alone", 0, 7, 0, 7, 0);
        rd("t4_amt0_noop", 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            set_inc(0, 1'b1, 2);
            tick();
        end
        set_inc(0, 1'b1, 9);
        do_start(3);
        chk_state("t4_restart", 1'b1, 1'b0);
        set_inc(0, 1'b1, 1);
        set_inc(1, 1'b1, 5);
        set_inc(2, 1'b1, 2);
        rd("t4_shadow_kept", 0, 7, 0, 7, 0);
        tick();
        tick();
        inc_valid = '0;
        chk_state("t4_win_end", 1'b0, 1'b1);

        // 5: back-to-back reads including an out-of-range index
        rd("t5_idx3", 3, 0, 0, 0, 0);
        rd("t5_ch0", 0, 3, 0, 3, 0);
        rd("t5_ch1", 1, 15, 0, 15, 0);
        rd("t5_ch2", 2, 6, 0, 6, 0);
        tick();
        chk("t5_hold_sat",  32'(rd_data_s), 32'd6);
        chk("t5_hold_wrap", 32'(rd_data_w), 32'd6);

        // 6: reset mid-window
        do_start(0);
        for (int k = 0; k < 5; k++) begin
            set_inc(0, 1'b1, 8);
            set_inc(1, 1'b1, 8);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("t6_reset", 1'b0, 1'b0);
        chk("t6_rd_data", 32'(rd_data_s), 32'd0);
        chk("t6_rd_ovf",  32'(rd_ovf_s),  32'd0);
        for (int k = 0; k < 3; k++) tick();
        chk_state("t6_idle", 1'b0, 1'b0);
        rd("t6_shadow0", 0, 0, 0, 0, 0);
        rd("t6_shadow1", 1, 0, 0, 0, 0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        rd("t6_live_ignored", 0, 0, 0, 0, 0);
        do_start(0);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        inc_valid = '0;
        rd("t6_after_restart_ch0", 0, 24, 0, 24, 0);
        rd("t6_after_restart_ch1", 1, 24, 0, 24, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
